// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester req/ack ports plus the shared data-memory bus.
// slave = arbiter side, master = requesters and memory side.
interface dmem_arbiter_if #(
   parameter int AW = 8,
   parameter int DW = 8
);
   logic          req0;
   logic          we0;
   logic [AW-1:0] addr0;
   logic [DW-1:0] wdata0;
   logic          ack0;
   logic [DW-1:0] rdata0;

   logic          req1;
   logic          we1;
   logic [AW-1:0] addr1;
   logic [DW-1:0] wdata1;
   logic          ack1;
   logic [DW-1:0] rdata1;

   logic          mem_MW;
   logic [AW-1:0] mem_address;
   logic [DW-1:0] mem_data_in;
   logic [DW-1:0] mem_data_out;

   logic          busy;
   logic          grant;

   modport slave (
      input  req0, we0, addr0, wdata0,
      input  req1, we1, addr1, wdata1,
      input  mem_data_out,
      output ack0, rdata0, ack1, rdata1,
      output mem_MW, mem_address, mem_data_in,
      output busy, grant
   );

   modport master (
      output req0, we0, addr0, wdata0,
      output req1, we1, addr1, wdata1,
      output mem_data_out,
      input  ack0, rdata0, ack1, rdata1,
      input  mem_MW, mem_address, mem_data_in,
      input  busy, grant
   );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of the 256x8 negedge-sampled data memory; one access per IDLE/ACCESS/RESP pass.
// Define DMEM_ARB_FIXED_PRIORITY_EN for fixed priority (port 0 wins ties); default is round-robin.
module dmem_arbiter #(
   parameter int AW = 8,
   parameter int DW = 8
) (
   input logic          clock,
   input logic          reset,
   dmem_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ACCESS,
      S_RESP
   } state_t;

   state_t        r_state;
   logic          r_we_q;
   logic          r_grant;
   logic          r_busy;
   logic          r_mem_mw;
   logic [AW-1:0] r_mem_address;
   logic [DW-1:0] r_mem_data_in;
   logic          r_ack0;
   logic          r_ack1;
   logic [DW-1:0] r_rdata0;
   logic [DW-1:0] r_rdata1;
   logic          w_any_req;
   logic          w_win;

`ifndef DMEM_ARB_FIXED_PRIORITY_EN
   logic          r_last_grant;
`endif

   assign w_any_req = bus.req0 | bus.req1;

   always_comb begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
      w_win = ~bus.req0;
`else
      if (bus.req0 && bus.req1) begin
         w_win = ~r_last_grant;
      end else begin
         w_win = ~bus.req0;
      end
`endif
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_we_q        <= 1'b0;
         r_grant       <= 1'b1;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
         r_last_grant  <= 1'b1;
`endif
         r_busy        <= 1'b0;
         r_mem_mw      <= 1'b0;
         r_mem_address <= '0;
         r_mem_data_in <= '0;
         r_ack0        <= 1'b0;
         r_ack1        <= 1'b0;
         r_rdata0      <= '0;
         r_rdata1      <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_mem_mw <= 1'b0;
               if (w_any_req) begin
                  r_grant       <= w_win;
`ifndef DMEM_ARB_FIXED_PRIORITY_EN
                  r_last_grant  <= w_win;
`endif
                  r_mem_address <= w_win ? bus.addr1  : bus.addr0;
                  r_mem_data_in <= w_win ? bus.wdata1 : bus.wdata0;
                  r_we_q        <= w_win ? bus.we1    : bus.we0;
                  // Write strobe is registered here so it is high for exactly the ACCESS cycle.
                  r_mem_mw      <= w_win ? bus.we1    : bus.we0;
                  r_busy        <= 1'b1;
                  r_state       <= S_ACCESS;
               end
            end

            S_ACCESS: begin
               r_mem_mw <= 1'b0;
               if (r_grant) begin
                  r_ack1 <= 1'b1;
                  if (!r_we_q) r_rdata1 <= bus.mem_data_out;
               end else begin
                  r_ack0 <= 1'b1;
                  if (!r_we_q) r_rdata0 <= bus.mem_data_out;
               end
               r_state <= S_RESP;
            end

            S_RESP: begin
               r_ack0  <= 1'b0;
               r_ack1  <= 1'b0;
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end

            default: begin
               r_mem_mw <= 1'b0;
               r_ack0   <= 1'b0;
               r_ack1   <= 1'b0;
               r_busy   <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.mem_MW      = r_mem_mw;
   assign bus.mem_address = r_mem_address;
   assign bus.mem_data_in = r_mem_data_in;
   assign bus.ack0        = r_ack0;
   assign bus.ack1        = r_ack1;
   assign bus.rdata0      = r_rdata0;
   assign bus.rdata1      = r_rdata1;
   assign bus.busy        = r_busy;
   assign bus.grant       = r_grant;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: negedge memory model plus a reference memory/arbitration model.
module tb_dmem_arbiter;
   localparam int AW = 8;
   localparam int DW = 8;

   logic clock = 1'b0;
   logic reset = 1'b1;

   dmem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   dmem_arbiter #(.AW(AW), .DW(DW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   logic [7:0] mem     [256];
   logic [7:0] ref_mem [256];
   int n_pass  = 0;
   int n_total = 0;

   // Data memory: samples MW/address/data_in and updates data_out on negedge.
   always @(negedge clock) begin
      if (bus.mem_MW === 1'b1) mem[bus.mem_address] = bus.mem_data_in;
      bus.mem_data_out <= mem[bus.mem_address];
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   task automatic do_reset();
      reset = 1'b1;
      bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
      bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
   endtask

   // Single access from one port, started and finished on a negedge; reports latency in posedges.
   task automatic run_access(input bit p, input bit we, input logic [7:0] a, input logic [7:0] d,
                             output bit ok, output logic [7:0] rd, output int edges);
      if (p) begin bus.we1 = we; bus.addr1 = a; bus.wdata1 = d; bus.req1 = 1'b1; end
      else   begin bus.we0 = we; bus.addr0 = a; bus.wdata0 = d; bus.req0 = 1'b1; end
      ok = 1'b0;
      edges = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         edges++;
         if ((p ? bus.ack1 : bus.ack0) === 1'b1) begin ok = 1'b1; break; end
      end
      rd = p ? bus.rdata1 : bus.rdata0;
      if (p) bus.req1 = 1'b0; else bus.req0 = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_total++;
      if ({bus.ack0, bus.ack1, bus.mem_MW, bus.busy} !== 4'b0000) begin
         $display("FAIL reset_ctrl: got %b expected 0000", {bus.ack0, bus.ack1, bus.mem_MW, bus.busy});
      end else n_pass++;
      n_total++;
      if ({bus.rdata0, bus.rdata1, bus.mem_address, bus.mem_data_in} !== 32'h0) begin
         $display("FAIL reset_data: got %h expected 0", {bus.rdata0, bus.rdata1, bus.mem_address, bus.mem_data_in});
      end else n_pass++;
      n_total++;
      if (bus.grant !== 1'b1) $display("FAIL reset_grant: got %b expected 1", bus.grant);
      else n_pass++;
   endtask

   task automatic test_reset_mid_access();
      bit ack_seen;
      bit ok;
      logic [7:0] rd;
      int e;
      do_reset();
      bus.we0 = 1'b1; bus.addr0 = 8'h50; bus.wdata0 = ~ref_mem[8'h50]; bus.req0 = 1'b1;
      @(posedge clock);
      #1;
      n_total++;
      if ({bus.busy, bus.mem_MW} !== 2'b11) $display("FAIL mid_in_access: got %b expected 11", {bus.busy, bus.mem_MW});
      else n_pass++;
      reset = 1'b1;
      #1;
      n_total++;
      if ({bus.mem_MW, bus.busy, bus.ack0, bus.mem_address, bus.mem_data_in} !== 19'h0) begin
         $display("FAIL mid_async_clear: got %h expected 0", {bus.mem_MW, bus.busy, bus.ack0, bus.mem_address, bus.mem_data_in});
      end else n_pass++;
      ack_seen = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clock);
         if (bus.ack0 === 1'b1) ack_seen = 1'b1;
      end
      bus.req0 = 1'b0;
      reset = 1'b0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         if (bus.ack0 === 1'b1) ack_seen = 1'b1;
      end
      n_total++;
      if (ack_seen !== 1'b0) $display("FAIL mid_no_ack: got %b expected 0", ack_seen);
      else n_pass++;
      run_access(1'b1, 1'b0, 8'h50, 8'h00, ok, rd, e);
      n_total++;
      if (!ok || rd !== ref_mem[8'h50]) $display("FAIL mid_prior_data: got %h expected %h", rd, ref_mem[8'h50]);
      else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_write_read();
      bit ok;
      logic [7:0] rd;
      int e;
      do_reset();
      run_access(1'b0, 1'b1, 8'h04, 8'h05, ok, rd, e);
      ref_mem[8'h04] = 8'h05;
      n_total++;
      if (!ok || e != 2) $display("FAIL wr_latency: got %0d expected 2", e);
      else n_pass++;
      n_total++;
      if (rd !== 8'h00) $display("FAIL wr_rdata_kept: got %h expected 00", rd);
      else n_pass++;
      @(negedge clock);
      n_total++;
      if (bus.ack0 !== 1'b0) $display("FAIL wr_ack_pulse: got %b expected 0", bus.ack0);
      else n_pass++;
      run_access(1'b0, 1'b0, 8'h04, 8'h00, ok, rd, e);
      n_total++;
      if (!ok || e != 2 || rd !== 8'h05) $display("FAIL rd_after_wr: got %h lat %0d expected 05 lat 2", rd, e);
      else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_tie();
      do_reset();
      bus.we0 = 1'b1; bus.addr0 = 8'h10; bus.wdata0 = 8'hAA; bus.req0 = 1'b1;
      bus.we1 = 1'b0; bus.addr1 = 8'h10; bus.wdata1 = 8'h00; bus.req1 = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) break;
      end
      n_total++;
      if ({bus.ack0, bus.ack1, bus.grant} !== 3'b100) $display("FAIL tie_first: got %b expected 100", {bus.ack0, bus.ack1, bus.grant});
      else n_pass++;
      ref_mem[8'h10] = 8'hAA;
      bus.req0 = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clock);
         if (bus.ack0 === 1'b1 || bus.ack1 === 1'b1) break;
      end
      bus.req1 = 1'b0;
      n_total++;
      if ({bus.ack0, bus.ack1, bus.grant} !== 3'b011 || bus.rdata1 !== 8'hAA) begin
         $display("FAIL tie_second: got %b/%h expected 011/aa", {bus.ack0, bus.ack1, bus.grant}, bus.rdata1);
      end else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_fairness();
      int got;
      int exp;
      logic [7:0] a0, a1;
      do_reset();
      a0 = 8'($urandom_range(0, 255));
      a1 = 8'($urandom_range(0, 255));
      bus.we0 = 1'b0; bus.addr0 = a0; bus.req0 = 1'b1;
      bus.we1 = 1'b0; bus.addr1 = a1; bus.req1 = 1'b1;
      for (int k = 0; k < 6; k++) begin
         got = -1;
         for (int c = 0; c < 12; c++) begin
            @(negedge clock);
            if (bus.ack0 === 1'b1) begin got = 0; break; end
            if (bus.ack1 === 1'b1) begin got = 1; break; end
         end
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
         exp = 0;
`else
         exp = k % 2;
`endif
         n_total++;
         if (got != exp || bus.grant !== 1'(exp)) $display("FAIL fair_grant%0d: got %0d expected %0d", k, got, exp);
         else n_pass++;
         n_total++;
         if ((exp == 0 ? bus.rdata0 : bus.rdata1) !== ref_mem[exp == 0 ? a0 : a1]) begin
            $display("FAIL fair_rdata%0d: got %h expected %h", k, exp == 0 ? bus.rdata0 : bus.rdata1, ref_mem[exp == 0 ? a0 : a1]);
         end else n_pass++;
      end
      bus.req0 = 1'b0;
      bus.req1 = 1'b0;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_loser_change();
      bit seen20, seen30, got1, ok;
      logic [7:0] rd;
      int e;
      do_reset();
      bus.we0 = 1'b1; bus.addr0 = 8'h40; bus.wdata0 = 8'h11; bus.req0 = 1'b1;
      bus.we1 = 1'b1; bus.addr1 = 8'h20; bus.wdata1 = 8'h77; bus.req1 = 1'b1;
      seen20 = 1'b0; seen30 = 1'b0; got1 = 1'b0;
      for (int c = 0; c < 16; c++) begin
         @(negedge clock);
         if (bus.mem_MW === 1'b1 && bus.mem_address === 8'h20) seen20 = 1'b1;
         if (bus.mem_MW === 1'b1 && bus.mem_address === 8'h30) seen30 = 1'b1;
         if (c == 0) bus.addr1 = 8'h30;
         if (bus.ack0 === 1'b1) bus.req0 = 1'b0;
         if (bus.ack1 === 1'b1) begin got1 = 1'b1; break; end
      end
      bus.req1 = 1'b0;
      ref_mem[8'h40] = 8'h11;
      ref_mem[8'h30] = 8'h77;
      n_total++;
      if ({got1, seen20, seen30} !== 3'b101) $display("FAIL loser_addr: got %b expected 101", {got1, seen20, seen30});
      else n_pass++;
      run_access(1'b1, 1'b0, 8'h30, 8'h00, ok, rd, e);
      n_total++;
      if (!ok || rd !== 8'h77) $display("FAIL loser_rd30: got %h expected 77", rd);
      else n_pass++;
      @(negedge clock);
      run_access(1'b1, 1'b0, 8'h20, 8'h00, ok, rd, e);
      n_total++;
      if (!ok || rd !== ref_mem[8'h20]) $display("FAIL loser_rd20: got %h expected %h", rd, ref_mem[8'h20]);
      else n_pass++;
      @(negedge clock);
   endtask

   task automatic test_back_to_back();
      bit s_busy [15];
      bit s_ack  [15];
      int acks, prev, gaps_bad, low_cnt;
      do_reset();
      bus.we0 = 1'b0; bus.addr0 = 8'($urandom_range(0, 255)); bus.req0 = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(negedge clock);
         s_busy[i] = bus.busy;
         s_ack[i]  = bus.ack0;
      end
      bus.req0 = 1'b0;
      acks = 0; prev = -1; gaps_bad = 0; low_cnt = 0;
      for (int i = 0; i < 15; i++) begin
         if (s_ack[i]) begin
            if (prev >= 0 && i - prev != 3) gaps_bad++;
            prev = i;
            acks++;
         end
      end
      for (int i = 1; i <= 13; i++) if (!s_busy[i]) low_cnt++;
      n_total++;
      if (acks != 5 || gaps_bad != 0) $display("FAIL b2b_acks: got %0d acks %0d bad gaps expected 5 acks 0 bad", acks, gaps_bad);
      else n_pass++;
      n_total++;
      if (low_cnt != 4) $display("FAIL b2b_busy_low: got %0d expected 4", low_cnt);
      else n_pass++;
      repeat (3) @(negedge clock);
   endtask

   task automatic test_random();
      bit pend0, pend1, last;
      bit w0, w1;
      logic [7:0] a0, a1, d0, d1;
      int exp, got;
      do_reset();
      last = 1'b1;
      for (int r = 0; r < 30; r++) begin
         pend0 = 1'($urandom_range(0, 1));
         pend1 = 1'($urandom_range(0, 1));
         if (!pend0 && !pend1) pend0 = 1'b1;
         w0 = 1'($urandom_range(0, 1)); a0 = 8'($urandom_range(0, 15)); d0 = 8'($urandom);
         w1 = 1'($urandom_range(0, 1)); a1 = 8'($urandom_range(0, 15)); d1 = 8'($urandom);
         if (pend0) begin bus.we0 = w0; bus.addr0 = a0; bus.wdata0 = d0; bus.req0 = 1'b1; end
         if (pend1) begin bus.we1 = w1; bus.addr1 = a1; bus.wdata1 = d1; bus.req1 = 1'b1; end
         while (pend0 || pend1) begin
`ifdef DMEM_ARB_FIXED_PRIORITY_EN
            exp = pend0 ? 0 : 1;
`else
            exp = (pend0 && pend1) ? int'(!last) : (pend0 ? 0 : 1);
`endif
            got = -1;
            for (int c = 0; c < 12; c++) begin
               @(negedge clock);
               if (bus.ack0 === 1'b1) begin got = 0; break; end
               if (bus.ack1 === 1'b1) begin got = 1; break; end
            end
            n_total++;
            if (got != exp || bus.grant !== 1'(exp)) $display("FAIL rnd_grant r%0d: got %0d expected %0d", r, got, exp);
            else n_pass++;
            if (exp == 0) begin
               if (w0) ref_mem[a0] = d0;
               else begin
                  n_total++;
                  if (bus.rdata0 !== ref_mem[a0]) $display("FAIL rnd_rdata0 r%0d: got %h expected %h", r, bus.rdata0, ref_mem[a0]);
                  else n_pass++;
               end
               bus.req0 = 1'b0; pend0 = 1'b0;
            end else begin
               if (w1) ref_mem[a1] = d1;
               else begin
                  n_total++;
                  if (bus.rdata1 !== ref_mem[a1]) $display("FAIL rnd_rdata1 r%0d: got %h expected %h", r, bus.rdata1, ref_mem[a1]);
                  else n_pass++;
               end
               bus.req1 = 1'b0; pend1 = 1'b0;
            end
            last = 1'(exp);
            if (got < 0) begin
               bus.req0 = 1'b0; bus.req1 = 1'b0; pend0 = 1'b0; pend1 = 1'b0;
            end
         end
      end
      repeat (3) @(negedge clock);
   endtask

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 8'((i * 7 + 3) ^ 8'h5A);
         ref_mem[i] = 8'((i * 7 + 3) ^ 8'h5A);
      end
      bus.mem_data_out = '0;
      test_reset();
      test_reset_mid_access();
      test_write_read();
      test_tie();
      test_fairness();
      test_loser_change();
      test_back_to_back();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
